// File: rtl/ahb2apb_bridge_mp_if.sv
// AHB-Lite and APB4 signal bundles for ahb2apb_bridge_mp; no logic, no latency.
// Backpressure travels on HREADYout (AHB side) and PREADY (APB side).
interface ahb2apb_ahb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADYin;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADYout;
  logic [1:0]        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYin,
    input  HRDATA, HREADYout, HRESP
  );
  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYin,
    output HRDATA, HREADYout, HRESP
  );
endinterface

interface ahb2apb_apb_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 3
);
  logic [ADDR_W-1:0]         PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic [DATA_W/8-1:0]       PSTRB;
  logic [NUM_SLV-1:0]        PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]        PREADY;
  logic [NUM_SLV-1:0]        PSLVERR;

  modport master (
    output PADDR, PWDATA, PSTRB, PSEL, PENABLE, PWRITE,
    input  PRDATA, PREADY, PSLVERR
  );
  modport slave (
    input  PADDR, PWDATA, PSTRB, PSEL, PENABLE, PWRITE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahb2apb_bridge_mp.sv
// AHB-Lite to APB4 bridge over NUM_SLV windows; 3 stall cycles per zero-wait access, fully registered outputs.
// Backpressure: HREADYout low for CAPTURE/SETUP/ACCESS/ERR1, ACCESS held while PREADY is low or until TIMEOUT.
module ahb2apb_bridge_mp #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                REGION_BITS = 12,
  parameter int                TIMEOUT     = 0
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  ahb2apb_ahb_if.slave  ahb,
  ahb2apb_apb_if.master apb
);
  localparam int STRB_W = DATA_W / 8;
  localparam int SZ_MAX = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, CAPTURE, SETUP, ACCESS, ERR1, ERR2} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [2:0]        size;
    logic [IDX_W-1:0]  idx;
  } req_t;

  state_t              state_q, state_d;
  req_t                req_q;
  logic [TCNT_W-1:0]   tcnt_q;
  logic [DATA_W-1:0]   hrdata_q;
  logic                hready_q, hready_d;
  logic [1:0]          hresp_q, hresp_d;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [STRB_W-1:0]   pstrb_q;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q;

  logic [ADDR_W-1:0]   off, slot;
  logic [7:0]          size_mask;
  logic                accept, dec_ok, tmo_hit;
  logic                pready_sel, pslverr_sel;
  logic [DATA_W-1:0]   prdata_sel;
  logic [NUM_SLV-1:0]  sel_onehot;
  logic [15:0]         strb_lanes;
  logic [STRB_W-1:0]   strb_d;
  logic                htrans_unused;

  assign accept        = ahb.HSEL & ahb.HREADYin & ahb.HTRANS[1];
  assign htrans_unused = ahb.HTRANS[0];

  // Window decode plus size/alignment legality, evaluated on the address phase
  assign off       = ahb.HADDR - BASE_ADDR;
  assign slot      = off >> REGION_BITS;
  assign size_mask = (8'd1 << ahb.HSIZE) - 8'd1;
  assign dec_ok    = (ahb.HADDR >= BASE_ADDR) && (slot < ADDR_W'(NUM_SLV)) &&
                     (ahb.HSIZE <= 3'(SZ_MAX)) &&
                     ((size_mask & 8'(ahb.HADDR[2:0])) == 8'd0);

  assign pready_sel  = apb.PREADY[req_q.idx];
  assign pslverr_sel = apb.PSLVERR[req_q.idx];
  assign prdata_sel  = apb.PRDATA[req_q.idx*DATA_W +: DATA_W];
  assign sel_onehot  = NUM_SLV'(1) << req_q.idx;
  assign tmo_hit     = (TIMEOUT > 0) && (tcnt_q == TCNT_W'(TIMEOUT));

  assign strb_lanes = (16'd1 << (16'd1 << req_q.size)) - 16'd1;
  assign strb_d     = req_q.write ? STRB_W'(strb_lanes << req_q.addr[SZ_MAX-1:0]) : '0;

  always_comb begin
    state_d   = state_q;
    hready_d  = 1'b1;
    hresp_d   = 2'b00;
    psel_d    = '0;
    penable_d = 1'b0;
    unique case (state_q)
      IDLE, ERR2: begin
        if (accept) state_d = dec_ok ? CAPTURE : ERR1;
        else        state_d = IDLE;
      end
      CAPTURE: state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (pready_sel)   state_d = pslverr_sel ? ERR1 : IDLE;
        else if (tmo_hit) state_d = ERR1;
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
    // Registered outputs are decoded from the state being entered
    case (state_d)
      CAPTURE: hready_d = 1'b0;
      SETUP: begin
        hready_d = 1'b0;
        psel_d   = sel_onehot;
      end
      ACCESS: begin
        hready_d  = 1'b0;
        psel_d    = sel_onehot;
        penable_d = 1'b1;
      end
      ERR1: begin
        hready_d = 1'b0;
        hresp_d  = 2'b01;
      end
      ERR2:    hresp_d = 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      req_q     <= '0;
      tcnt_q    <= '0;
      hrdata_q  <= '0;
      hready_q  <= 1'b1;
      hresp_q   <= 2'b00;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hready_q  <= hready_d;
      hresp_q   <= hresp_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      if ((state_q == IDLE || state_q == ERR2) && accept) begin
        req_q <= '{addr: ahb.HADDR, write: ahb.HWRITE, size: ahb.HSIZE,
                   idx: slot[IDX_W-1:0]};
      end
      if (state_q == CAPTURE) begin
        paddr_q  <= req_q.addr;
        pwrite_q <= req_q.write;
        pstrb_q  <= strb_d;
        if (req_q.write) pwdata_q <= ahb.HWDATA;
      end
      if (state_d == ACCESS) tcnt_q <= (state_q == ACCESS) ? tcnt_q + TCNT_W'(1) : TCNT_W'(1);
      else                   tcnt_q <= '0;
      if (state_q == ACCESS && pready_sel && !req_q.write) hrdata_q <= prdata_sel;
    end
  end

  assign ahb.HRDATA    = hrdata_q;
  assign ahb.HREADYout = hready_q;
  assign ahb.HRESP     = hresp_q;
  assign apb.PADDR     = paddr_q;
  assign apb.PWDATA    = pwdata_q;
  assign apb.PSTRB     = pstrb_q;
  assign apb.PSEL      = psel_q;
  assign apb.PENABLE   = penable_q;
  assign apb.PWRITE    = pwrite_q;
endmodule

// File: tb/tb_ahb2apb_bridge_mp.sv
// Bench for ahb2apb_bridge_mp: directed scenarios plus randomized transfers scored against a per-transfer model.
module tb_ahb2apb_bridge_mp;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NS   = 3;
  localparam int          TO   = 4;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  ahb2apb_ahb_if #(.ADDR_W(AW), .DATA_W(DW)) ahb ();
  ahb2apb_apb_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) apb ();

  ahb2apb_bridge_mp #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .BASE_ADDR(BASE),
    .REGION_BITS(12), .TIMEOUT(TO)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb(ahb.slave), .apb(apb.master)
  );

  typedef struct {
    int          low;       // data-phase cycles with HREADYout low
    logic [1:0]  resp_low;  // HRESP in the last low cycle
    logic [1:0]  resp_fin;  // HRESP in the cycle HREADYout returns high
    int          psel_cyc;
    int          pen_cyc;
    int          bad;       // PSEL not one-hot or PENABLE without PSEL
    logic [2:0]  psel_or;
    logic [31:0] paddr, pwdata, hrdata;
    logic [3:0]  pstrb;
    logic        pwrite;
  } res_t;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hrdata = '0;
  logic [31:0] m_pwdata = '0;

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic rand_slaves;
    apb.PREADY  = NS'($urandom);
    apb.PSLVERR = NS'($urandom);
    for (int i = 0; i < NS; i++) apb.PRDATA[i*DW +: DW] = $urandom;
  endtask

  // Transfer-level reference: outcome derived from the address map, size rules and slave behaviour.
  task automatic model(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                       input logic [31:0] wd, input int waits, input logic err,
                       input logic [31:0] rd, output res_t e);
    bit legal, timed_out, fail;
    int slot, acc, lo;
    legal = (addr >= BASE) && (((addr - BASE) >> 12) < NS) && (sz <= 3'd2) &&
            ((addr % (32'd1 << sz)) == 0);
    slot = legal ? int'((addr - BASE) >> 12) : -1;
    e.bad = 0;
    e.paddr = addr;
    e.pwrite = wr;
    e.pstrb = '0;
    e.psel_or = '0;
    for (int i = 0; i < NS; i++) e.psel_or[i] = (i == slot);
    if (!legal) begin
      e.low = 1; e.resp_low = 2'b01; e.resp_fin = 2'b01;
      e.psel_cyc = 0; e.pen_cyc = 0;
    end else begin
      timed_out = (waits >= TO);
      acc = timed_out ? TO : waits + 1;
      fail = timed_out || err;
      e.pen_cyc = acc;
      e.psel_cyc = acc + 1;
      e.low = 2 + acc + (fail ? 1 : 0);
      e.resp_low = fail ? 2'b01 : 2'b00;
      e.resp_fin = fail ? 2'b01 : 2'b00;
      lo = int'(addr % 4);
      for (int b = 0; b < 4; b++) e.pstrb[b] = wr && (b >= lo) && (b < lo + (1 << sz));
      if (wr) m_pwdata = wd;
      if (!wr && !timed_out) m_hrdata = rd;
    end
    e.pwdata = m_pwdata;
    e.hrdata = m_hrdata;
  endtask

  // Drives one transfer (accepted at the first edge) and plays the addressed slave.
  task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                          input logic [31:0] wd, input int waits, input logic err,
                          input logic [31:0] rd, output res_t o);
    int acc, idx;
    bit done;
    o.low = 0; o.resp_low = 2'b00; o.resp_fin = 2'b11; o.psel_cyc = 0; o.pen_cyc = 0;
    o.bad = 0; o.psel_or = '0; o.paddr = '0; o.pwdata = '0; o.hrdata = '0;
    o.pstrb = '0; o.pwrite = 1'b0;
    ahb.HSEL = 1'b1; ahb.HREADYin = 1'b1; ahb.HTRANS = 2'b10;
    ahb.HADDR = addr; ahb.HWRITE = wr; ahb.HSIZE = sz;
    tick();
    ahb.HTRANS = 2'($urandom_range(0, 1));
    ahb.HSEL = 1'($urandom);
    ahb.HADDR = $urandom;
    ahb.HWRITE = 1'($urandom);
    ahb.HWDATA = wd;
    acc = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      rand_slaves();
      if (apb.PSEL != '0) begin
        o.psel_cyc++;
        o.psel_or |= apb.PSEL;
        o.paddr = apb.PADDR; o.pwdata = apb.PWDATA; o.pstrb = apb.PSTRB; o.pwrite = apb.PWRITE;
        if (!$onehot(apb.PSEL)) o.bad++;
        idx = 0;
        for (int i = 0; i < NS; i++) if (apb.PSEL[i]) idx = i;
        if (apb.PENABLE) begin
          acc++;
          o.pen_cyc++;
          apb.PREADY[idx] = (acc > waits);
          apb.PSLVERR[idx] = err;
          apb.PRDATA[idx*DW +: DW] = rd;
        end
      end else if (apb.PENABLE) begin
        o.bad++;
      end
      if (ahb.HREADYout) begin
        o.resp_fin = ahb.HRESP;
        o.hrdata = ahb.HRDATA;
        done = 1;
      end else begin
        o.low++;
        o.resp_low = ahb.HRESP;
        tick();
      end
    end
    if (!done) o.low = 999;
  endtask

  task automatic test_reset;
    HRESETn = 1'b0;
    ahb.HSEL = 1'b0; ahb.HADDR = '0; ahb.HTRANS = 2'b00; ahb.HWRITE = 1'b0;
    ahb.HSIZE = 3'd0; ahb.HWDATA = '0; ahb.HREADYin = 1'b1;
    apb.PREADY = '0; apb.PSLVERR = '0; apb.PRDATA = '0;
    tick(); tick();
    checks++; if (ahb.HREADYout !== 1'b1) begin failures++; $display("FAIL rst.hready got %b want 1", ahb.HREADYout); end
    checks++; if (ahb.HRESP !== 2'b00) begin failures++; $display("FAIL rst.hresp got %b want 00", ahb.HRESP); end
    checks++; if (ahb.HRDATA !== '0) begin failures++; $display("FAIL rst.hrdata got %h want 0", ahb.HRDATA); end
    checks++; if (apb.PADDR !== '0) begin failures++; $display("FAIL rst.paddr got %h want 0", apb.PADDR); end
    checks++; if (apb.PWDATA !== '0) begin failures++; $display("FAIL rst.pwdata got %h want 0", apb.PWDATA); end
    checks++; if (apb.PSTRB !== '0) begin failures++; $display("FAIL rst.pstrb got %b want 0", apb.PSTRB); end
    checks++; if (apb.PSEL !== '0 || apb.PENABLE !== 1'b0 || apb.PWRITE !== 1'b0) begin
      failures++; $display("FAIL rst.apbctl got psel=%b pen=%b pwr=%b want 0/0/0", apb.PSEL, apb.PENABLE, apb.PWRITE); end
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_single_write;
    res_t o;
    run_xfer(32'h8000_1004, 1'b1, 3'd2, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, o);
    checks++; if (o.low !== 3) begin failures++; $display("FAIL wr.low got %0d want 3", o.low); end
    checks++; if (o.psel_or !== 3'b010 || o.psel_cyc !== 2 || o.pen_cyc !== 1 || o.bad !== 0) begin
      failures++; $display("FAIL wr.psel got or=%b cyc=%0d pen=%0d bad=%0d want 010/2/1/0", o.psel_or, o.psel_cyc, o.pen_cyc, o.bad); end
    checks++; if (o.paddr !== 32'h8000_1004 || o.pwdata !== 32'hDEAD_BEEF || o.pwrite !== 1'b1) begin
      failures++; $display("FAIL wr.bus got %h/%h/%b want 80001004/deadbeef/1", o.paddr, o.pwdata, o.pwrite); end
    checks++; if (o.pstrb !== 4'hF) begin failures++; $display("FAIL wr.pstrb got %b want 1111", o.pstrb); end
    checks++; if (o.resp_fin !== 2'b00) begin failures++; $display("FAIL wr.hresp got %b want 00", o.resp_fin); end
  endtask

  task automatic test_read_wait;
    res_t o;
    run_xfer(32'h8000_2008, 1'b0, 3'd2, 32'h0, 3, 1'b0, 32'h1234_5678, o);
    checks++; if (o.low !== 6) begin failures++; $display("FAIL rdw.low got %0d want 6", o.low); end
    checks++; if (o.hrdata !== 32'h1234_5678) begin failures++; $display("FAIL rdw.hrdata got %h want 12345678", o.hrdata); end
    checks++; if (o.psel_or !== 3'b100 || o.pen_cyc !== 4 || o.pstrb !== 4'b0000) begin
      failures++; $display("FAIL rdw.apb got psel=%b pen=%0d strb=%b want 100/4/0000", o.psel_or, o.pen_cyc, o.pstrb); end
  endtask

  task automatic test_byte_strobe;
    res_t o;
    run_xfer(32'h8000_0003, 1'b1, 3'd0, 32'hAABB_CCDD, 0, 1'b0, 32'h0, o);
    checks++; if (o.pstrb !== 4'b1000) begin failures++; $display("FAIL byte.pstrb got %b want 1000", o.pstrb); end
    run_xfer(32'h8000_0006, 1'b1, 3'd1, 32'h0102_0304, 1, 1'b0, 32'h0, o);
    checks++; if (o.pstrb !== 4'b1100 || o.low !== 4) begin
      failures++; $display("FAIL half.pstrb got %b low=%0d want 1100 low=4", o.pstrb, o.low); end
  endtask

  task automatic test_slave_error;
    res_t o;
    run_xfer(32'h8000_0010, 1'b1, 3'd2, 32'h5A5A_5A5A, 0, 1'b1, 32'h0, o);
    checks++; if (o.low !== 4 || o.resp_low !== 2'b01) begin
      failures++; $display("FAIL serr.err1 got low=%0d resp=%b want 4/01", o.low, o.resp_low); end
    checks++; if (o.resp_fin !== 2'b01) begin failures++; $display("FAIL serr.err2 got %b want 01", o.resp_fin); end
    ahb.HTRANS = 2'b00;
    tick();
    checks++; if (ahb.HREADYout !== 1'b1 || ahb.HRESP !== 2'b00) begin
      failures++; $display("FAIL serr.idle got hready=%b resp=%b want 1/00", ahb.HREADYout, ahb.HRESP); end
  endtask

  task automatic test_unmapped;
    res_t o;
    logic [31:0] addrs [3] = '{32'h8000_3000, 32'h8000_0002, 32'h7FFF_FFFC};
    logic [2:0]  sizes [3] = '{3'd2, 3'd2, 3'd2};
    for (int i = 0; i < 3; i++) begin
      run_xfer(addrs[i], 1'b0, sizes[i], 32'h0, 0, 1'b0, 32'h0, o);
      checks++; if (o.low !== 1 || o.psel_cyc !== 0 || o.resp_low !== 2'b01 || o.resp_fin !== 2'b01) begin
        failures++; $display("FAIL unmap%0d got low=%0d psel=%0d resp=%b/%b want 1/0/01/01", i, o.low, o.psel_cyc, o.resp_low, o.resp_fin); end
    end
    run_xfer(32'h8000_0008, 1'b1, 3'd3, 32'h0, 0, 1'b0, 32'h0, o);
    checks++; if (o.low !== 1 || o.psel_cyc !== 0 || o.resp_fin !== 2'b01) begin
      failures++; $display("FAIL size3 got low=%0d psel=%0d resp=%b want 1/0/01", o.low, o.psel_cyc, o.resp_fin); end
  endtask

  task automatic test_timeout;
    res_t o;
    run_xfer(32'h8000_0020, 1'b0, 3'd2, 32'h0, 20, 1'b0, 32'h5555_5555, o);
    checks++; if (o.pen_cyc !== TO || o.psel_or !== 3'b001) begin
      failures++; $display("FAIL tmo.access got %0d psel=%b want %0d/001", o.pen_cyc, o.psel_or, TO); end
    checks++; if (o.low !== 7 || o.resp_low !== 2'b01 || o.resp_fin !== 2'b01) begin
      failures++; $display("FAIL tmo.resp got low=%0d resp=%b/%b want 7/01/01", o.low, o.resp_low, o.resp_fin); end
    checks++; if (o.hrdata !== 32'h1234_5678) begin failures++; $display("FAIL tmo.hrdata got %h want 12345678", o.hrdata); end
  endtask

  task automatic test_back_to_back;
    res_t o1, o2;
    run_xfer(32'h8000_0100, 1'b1, 3'd2, 32'h1111_1111, 0, 1'b0, 32'h0, o1);
    run_xfer(32'h8000_2200, 1'b1, 3'd2, 32'h2222_2222, 1, 1'b0, 32'h0, o2);
    checks++; if (o1.psel_or !== 3'b001 || o1.pwdata !== 32'h1111_1111 || o1.low !== 3) begin
      failures++; $display("FAIL b2b.first got psel=%b wd=%h low=%0d want 001/11111111/3", o1.psel_or, o1.pwdata, o1.low); end
    checks++; if (o2.low !== 4 || o2.psel_or !== 3'b100) begin
      failures++; $display("FAIL b2b.second got low=%0d psel=%b want 4/100", o2.low, o2.psel_or); end
    checks++; if (o2.paddr !== 32'h8000_2200 || o2.pwdata !== 32'h2222_2222) begin
      failures++; $display("FAIL b2b.bus got %h/%h want 80002200/22222222", o2.paddr, o2.pwdata); end
  endtask

  task automatic test_no_accept;
    ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HREADYin = 1'b0; ahb.HADDR = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ahb.HREADYout !== 1'b1 || apb.PSEL !== '0) begin
        failures++; $display("FAIL hrdyin%0d got hready=%b psel=%b want 1/000", i, ahb.HREADYout, apb.PSEL); end
    end
    ahb.HREADYin = 1'b1; ahb.HTRANS = 2'b01;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (ahb.HREADYout !== 1'b1 || ahb.HRESP !== 2'b00 || apb.PSEL !== '0) begin
        failures++; $display("FAIL busy%0d got hready=%b resp=%b psel=%b want 1/00/000", i, ahb.HREADYout, ahb.HRESP, apb.PSEL); end
    end
    ahb.HTRANS = 2'b00;
  endtask

  task automatic test_reset_abort;
    apb.PREADY = '0; apb.PSLVERR = '0;
    ahb.HSEL = 1'b1; ahb.HREADYin = 1'b1; ahb.HTRANS = 2'b10;
    ahb.HADDR = 32'h8000_1000; ahb.HWRITE = 1'b0; ahb.HSIZE = 3'd2;
    tick();
    ahb.HTRANS = 2'b00;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (apb.PSEL !== 3'b010 || apb.PENABLE !== 1'b1) begin
      failures++; $display("FAIL abort.stall got psel=%b pen=%b want 010/1", apb.PSEL, apb.PENABLE); end
    HRESETn = 1'b0;
    tick();
    checks++; if (apb.PSEL !== '0 || apb.PENABLE !== 1'b0 || ahb.HREADYout !== 1'b1 || ahb.HRESP !== 2'b00) begin
      failures++; $display("FAIL abort.ctl got psel=%b pen=%b hready=%b resp=%b want 000/0/1/00", apb.PSEL, apb.PENABLE, ahb.HREADYout, ahb.HRESP); end
    checks++; if (ahb.HRDATA !== '0 || apb.PADDR !== '0 || apb.PWDATA !== '0 || apb.PSTRB !== '0 || apb.PWRITE !== 1'b0) begin
      failures++; $display("FAIL abort.regs got %h/%h/%h/%b/%b want all 0", ahb.HRDATA, apb.PADDR, apb.PWDATA, apb.PSTRB, apb.PWRITE); end
    HRESETn = 1'b1;
    apb.PREADY = '1;
    tick(); tick();
    checks++; if (ahb.HREADYout !== 1'b1 || ahb.HRESP !== 2'b00 || apb.PSEL !== '0) begin
      failures++; $display("FAIL abort.after got hready=%b resp=%b psel=%b want 1/00/000", ahb.HREADYout, ahb.HRESP, apb.PSEL); end
    m_hrdata = '0;
    m_pwdata = '0;
  endtask

  task automatic test_random;
    res_t o, e;
    logic [31:0] addr, wd, rd;
    logic [2:0]  sz;
    logic        wr, err;
    int          slot, waits;
    for (int n = 0; n < 150; n++) begin
      slot = $urandom_range(0, 4);
      if (slot == 4) addr = BASE - 32'($urandom_range(1, 4096));
      else           addr = BASE + 32'(slot) * 32'h1000 + 32'($urandom_range(0, 4095));
      sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      wr = 1'($urandom);
      err = ($urandom_range(0, 3) == 0);
      waits = $urandom_range(0, 5);
      wd = $urandom;
      rd = $urandom;
      model(addr, wr, sz, wd, waits, err, rd, e);
      run_xfer(addr, wr, sz, wd, waits, err, rd, o);
      checks++; if (o.low !== e.low || o.resp_low !== e.resp_low || o.resp_fin !== e.resp_fin) begin
        failures++; $display("FAIL rnd%0d.ahb a=%h got low=%0d resp=%b/%b want %0d/%b/%b", n, addr, o.low, o.resp_low, o.resp_fin, e.low, e.resp_low, e.resp_fin); end
      checks++; if (o.psel_or !== e.psel_or || o.psel_cyc !== e.psel_cyc || o.pen_cyc !== e.pen_cyc || o.bad !== 0) begin
        failures++; $display("FAIL rnd%0d.psel a=%h got %b/%0d/%0d/%0d want %b/%0d/%0d/0", n, addr, o.psel_or, o.psel_cyc, o.pen_cyc, o.bad, e.psel_or, e.psel_cyc, e.pen_cyc); end
      checks++; if (o.hrdata !== e.hrdata) begin
        failures++; $display("FAIL rnd%0d.hrdata got %h want %h", n, o.hrdata, e.hrdata); end
      if (e.psel_cyc > 0) begin
        checks++; if (o.paddr !== e.paddr || o.pwrite !== e.pwrite || o.pwdata !== e.pwdata || o.pstrb !== e.pstrb) begin
          failures++; $display("FAIL rnd%0d.apb got %h/%b/%h/%b want %h/%b/%h/%b", n, o.paddr, o.pwrite, o.pwdata, o.pstrb, e.paddr, e.pwrite, e.pwdata, e.pstrb); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_byte_strobe();
    test_slave_error();
    test_unmapped();
    test_timeout();
    test_back_to_back();
    test_no_accept();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
